blake2_msg_feeder: RTL and testbench

//  Upstream stage of the blake2 core. Accepts a message byte stream under valid/ready, slices it into

---
 rtl/blake2_msg_feeder_if.sv | 32 +++
 rtl/blake2_msg_feeder.sv | 237 +++++++++++++++++++++++
 tb/tb_blake2_msg_feeder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/blake2_msg_feeder_if.sv
// Byte-stream and core-side signal bundle for blake2_msg_feeder.
// The master modport is the environment (upstream source plus core);
// the slave modport is the feeder itself.
interface blake2_msg_feeder_if #(
    parameter int BB    = 128,
    parameter int IDX_W = 7
) ();
    logic             byte_v_i;
    logic [7:0]       byte_i;
    logic             byte_last_i;
    logic             byte_empty_i;
    logic             byte_ready_o;
    logic             core_ready_i;
    logic             data_v_o;
    logic [IDX_W-1:0] data_idx_o;
    logic [7:0]       data_o;
    logic             block_first_o;
    logic             block_last_o;
    logic [BB-1:0]    ll_o;

    modport master (
        output byte_v_i, byte_i, byte_last_i, byte_empty_i, core_ready_i,
        input  byte_ready_o, data_v_o, data_idx_o, data_o,
               block_first_o, block_last_o, ll_o
    );

    modport slave (
        input  byte_v_i, byte_i, byte_last_i, byte_empty_i, core_ready_i,
        output byte_ready_o, data_v_o, data_idx_o, data_o,
               block_first_o, block_last_o, ll_o
    );
endinterface

// File: rtl/blake2_msg_feeder.sv
// blake2_msg_feeder: slices an upstream byte stream into BLOCK_BYTES blocks,
// zero-pads the final block and feeds the blake2 core one byte per cycle.
// It only streams while the core is ready and stalls upstream across the
// core's compression gap (ready falls, then rises again).
// Optional feature: define BLAKE2_FEED_KEY_EN to add the kk_i key-length
// input; the first kk_i bytes then form a zero-padded key block.
module blake2_msg_feeder #(
    parameter int BB          = 128,
    parameter int BLOCK_BYTES = 64,
    parameter int IDX_W       = 7,
    parameter int KK_W        = 7
) (
    input  logic                clk,
    input  logic                nreset,
`ifdef BLAKE2_FEED_KEY_EN
    input  logic [KK_W-1:0]     kk_i,
`endif
    blake2_msg_feeder_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_PAD    = 3'd2,
        S_GAP_LO = 3'd3,
        S_GAP_HI = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

    state_t           state_r, state_nxt;
    logic [IDX_W-1:0] idx_r, idx_nxt;
    logic             first_r, first_nxt;
    logic             last_r, last_nxt;
    logic             done_r, done_nxt;     // message fully accepted
    logic             fresh_r, fresh_nxt;   // nothing accepted yet in this message
    logic             ready_r, ready_nxt;
    logic             data_v_r, data_v_nxt;
    logic [IDX_W-1:0] data_idx_r, data_idx_nxt;
    logic [7:0]       data_r, data_nxt;
    logic [BB-1:0]    ll_r, ll_nxt;

    logic             accept_s;
    logic             at_end_s;
    logic [BB-1:0]    ll_base_s;
    logic             in_key_s;
    logic             key_end_s;

`ifdef BLAKE2_FEED_KEY_EN
    logic [KK_W-1:0]  kk_r, kk_nxt;
    logic [KK_W-1:0]  key_cnt_r, key_cnt_nxt;

    assign in_key_s  = (kk_r != {KK_W{1'b0}}) && (key_cnt_r < kk_r);
    assign key_end_s = in_key_s && (key_cnt_r == (kk_r - KK_W'(1)));
`else
    assign in_key_s  = 1'b0;
    assign key_end_s = 1'b0;
`endif

    assign accept_s  = bus.byte_v_i & ready_r;
    assign at_end_s  = (idx_r == LAST_IDX);
    // The byte count restarts at the first accept of every message.
    assign ll_base_s = fresh_r ? {BB{1'b0}} : ll_r;

    // Next-state and next-output decode for the block slicer.
    always_comb begin
        state_nxt    = state_r;
        idx_nxt      = idx_r;
        first_nxt    = first_r;
        last_nxt     = last_r;
        done_nxt     = done_r;
        fresh_nxt    = fresh_r;
        data_v_nxt   = 1'b0;
        data_idx_nxt = data_idx_r;
        data_nxt     = data_r;
        ll_nxt       = ll_r;
`ifdef BLAKE2_FEED_KEY_EN
        kk_nxt       = kk_r;
        key_cnt_nxt  = key_cnt_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (bus.core_ready_i) begin
                    state_nxt = S_STREAM;
                    idx_nxt   = {IDX_W{1'b0}};
                    first_nxt = 1'b1;
                    last_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                    fresh_nxt = 1'b1;
`ifdef BLAKE2_FEED_KEY_EN
                    kk_nxt      = kk_i;
                    key_cnt_nxt = {KK_W{1'b0}};
`endif
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_STREAM: begin
                if (accept_s) begin
                    if (bus.byte_last_i && bus.byte_empty_i) begin
                        // Zero-length tail: no byte, pad the rest of the block.
                        last_nxt  = 1'b1;
                        done_nxt  = 1'b1;
                        fresh_nxt = 1'b0;
                        ll_nxt    = ll_base_s;
                        state_nxt = S_PAD;
                    end else begin
                        data_v_nxt   = 1'b1;
                        data_nxt     = bus.byte_i;
                        data_idx_nxt = idx_r;
                        idx_nxt      = idx_r + IDX_W'(1);
                        fresh_nxt    = 1'b0;
                        if (in_key_s) begin
`ifdef BLAKE2_FEED_KEY_EN
                            key_cnt_nxt = key_cnt_r + KK_W'(1);
`endif
                            // A key block always counts as one full block.
                            if (key_end_s) begin
                                ll_nxt = BB'(BLOCK_BYTES);
                            end else begin
                                ll_nxt = ll_base_s;
                            end
                        end else begin
                            ll_nxt = ll_base_s + BB'(1);
                        end
                        if (bus.byte_last_i) begin
                            last_nxt  = 1'b1;
                            done_nxt  = 1'b1;
                            state_nxt = at_end_s ? S_GAP_LO : S_PAD;
                        end else if (key_end_s || at_end_s) begin
                            state_nxt = at_end_s ? S_GAP_LO : S_PAD;
                        end else begin
                            state_nxt = S_STREAM;
                        end
                    end
                end else begin
                    state_nxt = S_STREAM;
                end
            end
            S_PAD: begin
                data_v_nxt   = 1'b1;
                data_nxt     = 8'h00;
                data_idx_nxt = idx_r;
                idx_nxt      = idx_r + IDX_W'(1);
                if (at_end_s) begin
                    state_nxt = S_GAP_LO;
                end else begin
                    state_nxt = S_PAD;
                end
            end
            S_GAP_LO: begin
                // Core drops ready once it starts compressing the block.
                if (!bus.core_ready_i) begin
                    state_nxt = S_GAP_HI;
                end else begin
                    state_nxt = S_GAP_LO;
                end
            end
            S_GAP_HI: begin
                if (bus.core_ready_i) begin
                    if (done_r) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_STREAM;
                        idx_nxt   = {IDX_W{1'b0}};
                        first_nxt = 1'b0;
                        last_nxt  = 1'b0;
                    end
                end else begin
                    state_nxt = S_GAP_HI;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        ready_nxt = (state_nxt == S_STREAM);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Block bookkeeping and registered core-side outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            idx_r      <= {IDX_W{1'b0}};
            first_r    <= 1'b0;
            last_r     <= 1'b0;
            done_r     <= 1'b0;
            fresh_r    <= 1'b0;
            ready_r    <= 1'b0;
            data_v_r   <= 1'b0;
            data_idx_r <= {IDX_W{1'b0}};
            data_r     <= 8'h00;
            ll_r       <= {BB{1'b0}};
        end else begin
            idx_r      <= idx_nxt;
            first_r    <= first_nxt;
            last_r     <= last_nxt;
            done_r     <= done_nxt;
            fresh_r    <= fresh_nxt;
            ready_r    <= ready_nxt;
            data_v_r   <= data_v_nxt;
            data_idx_r <= data_idx_nxt;
            data_r     <= data_nxt;
            ll_r       <= ll_nxt;
        end
    end

`ifdef BLAKE2_FEED_KEY_EN
    // Key length latched at message start and running key-byte count.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            kk_r      <= {KK_W{1'b0}};
            key_cnt_r <= {KK_W{1'b0}};
        end else begin
            kk_r      <= kk_nxt;
            key_cnt_r <= key_cnt_nxt;
        end
    end
`endif

    assign bus.byte_ready_o  = ready_r;
    assign bus.data_v_o      = data_v_r;
    assign bus.data_idx_o    = data_idx_r;
    assign bus.data_o        = data_r;
    assign bus.block_first_o = first_r;
    assign bus.block_last_o  = last_r;
    assign bus.ll_o          = ll_r;

endmodule

// File: tb/tb_blake2_msg_feeder.sv
// Testbench for blake2_msg_feeder: random upstream pacing and a simple core
// model; emitted bytes are collected and compared against the expected
// padded block stream computed from the message contents.
module tb_blake2_msg_feeder;

    logic clk;
    logic nreset;
    logic hold;
    int   busy_cnt;
    int   checks;
    int   errors;
    logic [7:0] msg [0:255];

    typedef struct packed {
        logic [6:0] idx;
        logic [7:0] data;
        logic       first;
        logic       last;
    } rec_t;

    rec_t got[$];

    blake2_msg_feeder_if #(.BB(128), .IDX_W(7)) bus ();

`ifdef BLAKE2_FEED_KEY_EN
    logic [6:0] kk;
    assign kk = 7'd0;
`endif

    blake2_msg_feeder #(.BB(128), .BLOCK_BYTES(64), .IDX_W(7), .KK_W(7)) dut (
        .clk    (clk),
        .nreset (nreset),
`ifdef BLAKE2_FEED_KEY_EN
        .kk_i   (kk),
`endif
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: ready unless held off, busy a few cycles after byte 63.
    assign bus.core_ready_i = hold ? 1'b0 : (busy_cnt == 0);

    always @(posedge clk) begin
        if (bus.data_v_o && bus.data_idx_o == 7'd63) begin
            busy_cnt <= int'($urandom_range(3, 10));
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Collect every byte the feeder issues; none may appear while the core is busy.
    always @(negedge clk) begin
        if (nreset && bus.data_v_o) begin
            got.push_back({bus.data_idx_o, bus.data_o, bus.block_first_o, bus.block_last_o});
            chk("issue_while_core_busy", {127'd0, bus.core_ready_i}, 128'd1);
        end
    end

    task automatic send(input int n, input bit empty, input int abort_at);
        int i;
        int cyc;
        int beats;
        bit acc;
        bit gap;
        beats = empty ? 1 : n;
        i = 0;
        cyc = 0;
        @(negedge clk);
        while (i < beats && cyc < 4000 && !(abort_at > 0 && got.size() >= abort_at)) begin
            gap = ($urandom_range(0, 3) == 0);
            bus.byte_v_i     = !gap;
            bus.byte_i       = empty ? 8'hA5 : msg[i];
            bus.byte_last_i  = (i == beats - 1);
            bus.byte_empty_i = empty;
            acc = !gap && bus.byte_ready_o;
            @(negedge clk);
            cyc++;
            if (acc) i++;
        end
        bus.byte_v_i     = 1'b0;
        bus.byte_last_i  = 1'b0;
        bus.byte_empty_i = 1'b0;
        if (abort_at == 0) chk("send_accepted", 128'(i), 128'(beats));
    endtask

    task automatic check_msg(input int n, input string name);
        int   nb;
        int   total;
        int   cyc;
        rec_t r;
        logic [7:0] eb;
        nb    = (n == 0) ? 1 : (n + 63) / 64;
        total = nb * 64;
        cyc   = 0;
        while (got.size() < total && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_count"}, 128'(got.size()), 128'(total));
        for (int k = 0; k < total && k < got.size(); k++) begin
            r  = got[k];
            eb = (k < n) ? msg[k] : 8'h00;
            chk({name, "_byte"}, 128'({r.idx, r.data, r.first}),
                128'({7'(k % 64), eb, (k < 64)}));
            if (k % 64 == 63) chk({name, "_last"}, 128'(r.last), 128'((k / 64) == nb - 1));
        end
        chk({name, "_ll"}, bus.ll_o, 128'(n));
        repeat (4) @(negedge clk);
        chk({name, "_no_extra"}, 128'(got.size()), 128'(total));
        got.delete();
    endtask

    task automatic load_abc();
        msg[0] = 8'h61;
        msg[1] = 8'h62;
        msg[2] = 8'h63;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        busy_cnt = 0;
        nreset = 1'b0;
        hold = 1'b1;
        bus.byte_v_i = 1'b0;
        bus.byte_i = 8'h00;
        bus.byte_last_i = 1'b0;
        bus.byte_empty_i = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_data_v", 128'(bus.data_v_o), 128'd0);
        chk("rst_ready", 128'(bus.byte_ready_o), 128'd0);
        chk("rst_idx", 128'(bus.data_idx_o), 128'd0);
        chk("rst_data", 128'(bus.data_o), 128'd0);
        chk("rst_first", 128'(bus.block_first_o), 128'd0);
        chk("rst_last", 128'(bus.block_last_o), 128'd0);
        chk("rst_ll", bus.ll_o, 128'd0);

        // Core not ready in idle: upstream stalled, nothing issued.
        nreset = 1'b1;
        bus.byte_v_i = 1'b1;
        bus.byte_i = 8'h5A;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("hold_ready", 128'(bus.byte_ready_o), 128'd0);
            chk("hold_data_v", 128'(bus.data_v_o), 128'd0);
        end
        bus.byte_v_i = 1'b0;
        hold = 1'b0;

        // "abc".
        load_abc();
        send(3, 1'b0, 0);
        check_msg(3, "abc");

        // Exactly one full block, 00..3F.
        for (int k = 0; k < 64; k++) msg[k] = 8'(k);
        send(64, 1'b0, 0);
        check_msg(64, "full64");

        // 65 bytes spill into a second block.
        for (int k = 0; k < 65; k++) msg[k] = 8'($urandom_range(0, 255));
        send(65, 1'b0, 0);
        check_msg(65, "len65");

        // Empty message.
        send(0, 1'b1, 0);
        check_msg(0, "empty");

        // Random lengths and contents.
        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, 200));
            for (int k = 0; k < n; k++) msg[k] = 8'($urandom_range(0, 255));
            send(n, 1'b0, 0);
            check_msg(n, "rand");
        end

        // Reset in the middle of a block, then a clean message.
        for (int k = 0; k < 40; k++) msg[k] = 8'($urandom_range(0, 255));
        send(40, 1'b0, 11);
        chk("abort_reached", 128'(got.size() >= 11), 128'd1);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("midrst_data_v", 128'(bus.data_v_o), 128'd0);
        chk("midrst_ready", 128'(bus.byte_ready_o), 128'd0);
        @(negedge clk);
        chk("midrst_data_v_edge", 128'(bus.data_v_o), 128'd0);
        nreset = 1'b1;
        got.delete();
        load_abc();
        send(3, 1'b0, 0);
        check_msg(3, "abc_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
